// File: rtl/cbi980_tx_serializer.sv
// cbi980_tx_serializer
// Transmit-side serial engine for the cbi980 stereo audio link. Pulls one word
// per slot from the channel-0 / channel-1 streams and shifts it out as a
// two-slot frame on sclk / lrclk / sdout. Missing words are reported on tx_unf.
//
// Ports
//   clk, rst              system clock, synchronous active-high reset
//   txen                  transmit enable; a running frame always completes
//   mclk_rate             sclk half-period minus one, in clk cycles
//   octet_cnt             data bytes per slot (1..4; other codes mean 4)
//   rjust, lsb_first      slot justification and bit order
//   chN_data/valid/ready  per-channel word fetch; ready strobes on slot entry
//   tx_unf                one-cycle underrun pulse, [1]=ch1, [0]=ch0
//   sclk, lrclk, sdout    serial line (receiver samples on sclk rising)
//   busy                  high while a frame is in progress
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | line quiet, waiting for txen
// SLOT0 | shifting the channel-0 slot (lrclk=0)
// SLOT1 | shifting the channel-1 slot (lrclk=1); frame end decides next

module cbi980_tx_serializer #(
  parameter int SLOT_BITS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        txen,
  input  logic [2:0]  mclk_rate,
  input  logic [2:0]  octet_cnt,
  input  logic        rjust,
  input  logic        lsb_first,
  input  logic [31:0] ch0_data,
  input  logic        ch0_valid,
  output logic        ch0_ready,
  input  logic [31:0] ch1_data,
  input  logic        ch1_valid,
  output logic        ch1_ready,
  output logic [1:0]  tx_unf,
  output logic        sclk,
  output logic        lrclk,
  output logic        sdout,
  output logic        busy
);

  localparam int BW = $clog2(SLOT_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SLOT0 = 2'd1,
    SLOT1 = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 entry_q, entry_d;
  logic                 sclk_q, sclk_d;
  logic [2:0]           half_q, half_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [SLOT_BITS-1:0] shreg_q, shreg_d;
  logic [2:0]           rate_q, rate_d;
  logic [2:0]           oct_q, oct_d;
  logic                 rj_q, rj_d;
  logic                 lsb_q, lsb_d;

  logic                 slot0_entry, slot1_entry;
  logic [2:0]           rate_eff, oct_eff;
  logic                 rj_eff, lsb_eff;
  logic [31:0]          word;
  logic [SLOT_BITS-1:0] slot_vec;
  logic [SLOT_BITS-1:0] cur_bits;
  logic [2:0]           cur_half;
  logic [BW-1:0]        cur_bit;

  assign slot0_entry = entry_q && (state_q == SLOT0);
  assign slot1_entry = entry_q && (state_q == SLOT1);

  // On SLOT0 entry the configuration is being latched this very cycle, so the
  // live inputs are used; afterwards the latched copy governs the frame.
  assign rate_eff = slot0_entry ? mclk_rate : rate_q;
  assign oct_eff  = slot0_entry ? octet_cnt : oct_q;
  assign rj_eff   = slot0_entry ? rjust     : rj_q;
  assign lsb_eff  = slot0_entry ? lsb_first : lsb_q;

  // Word accepted on the entry cycle; an underrun transmits zeros.
  always_comb begin
    word = '0;
    if (slot0_entry && ch0_valid) begin
      word = ch0_data;
    end else if (slot1_entry && ch1_valid) begin
      word = ch1_data;
    end
  end

  // Slot image in transmit order: slot_vec[0] is the first bit on the line.
  always_comb begin
    int n_bits;
    int k;
    int idx;
    slot_vec = '0;
    k        = 0;
    idx      = 0;
    case (oct_eff)
      3'd1:    n_bits = 8;
      3'd2:    n_bits = 16;
      3'd3:    n_bits = 24;
      default: n_bits = 32;
    endcase
    for (int p = 0; p < SLOT_BITS; p++) begin
      k = rj_eff ? (p - (SLOT_BITS - n_bits)) : p;
      if ((k >= 0) && (k < n_bits)) begin
        idx = lsb_eff ? k : (n_bits - 1 - k);
        slot_vec[p] = word[idx[4:0]];
      end
    end
  end

  // The entry cycle starts each slot's counters from their load values
  // combinationally, so bit 0 appears on the line in that same cycle.
  assign cur_bits = entry_q ? slot_vec : shreg_q;
  assign cur_half = entry_q ? rate_eff : half_q;
  assign cur_bit  = entry_q ? BW'(SLOT_BITS - 1) : bit_q;

  always_comb begin
    state_d = state_q;
    entry_d = 1'b0;
    sclk_d  = sclk_q;
    half_d  = half_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    rate_d  = rate_q;
    oct_d   = oct_q;
    rj_d    = rj_q;
    lsb_d   = lsb_q;

    case (state_q)
      IDLE: begin
        sclk_d  = 1'b0;
        half_d  = '0;
        bit_d   = '0;
        shreg_d = '0;
        if (txen) begin
          state_d = SLOT0;
          entry_d = 1'b1;
        end
      end

      SLOT0, SLOT1: begin
        if (slot0_entry) begin
          rate_d = mclk_rate;
          oct_d  = octet_cnt;
          rj_d   = rjust;
          lsb_d  = lsb_first;
        end
        shreg_d = cur_bits;
        bit_d   = cur_bit;
        if (cur_half == 3'd0) begin
          half_d = rate_eff;
          sclk_d = ~sclk_q;
          if (sclk_q) begin
            // sclk falling: end of a bit
            if (cur_bit == '0) begin
              sclk_d = 1'b0;
              if (state_q == SLOT0) begin
                state_d = SLOT1;
                entry_d = 1'b1;
              end else if (txen) begin
                state_d = SLOT0;
                entry_d = 1'b1;
              end else begin
                state_d = IDLE;
              end
            end else begin
              bit_d   = cur_bit - BW'(1);
              shreg_d = cur_bits >> 1;
            end
          end
        end else begin
          half_d = cur_half - 3'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      entry_q <= 1'b0;
      sclk_q  <= 1'b0;
      half_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      rate_q  <= '0;
      oct_q   <= '0;
      rj_q    <= 1'b0;
      lsb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      sclk_q  <= sclk_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      rate_q  <= rate_d;
      oct_q   <= oct_d;
      rj_q    <= rj_d;
      lsb_q   <= lsb_d;
    end
  end

  assign ch0_ready = slot0_entry;
  assign ch1_ready = slot1_entry;
  assign tx_unf    = {slot1_entry & ~ch1_valid, slot0_entry & ~ch0_valid};
  assign sclk      = sclk_q;
  assign lrclk     = (state_q == SLOT1);
  assign busy      = (state_q != IDLE);
  assign sdout     = busy & cur_bits[0];

endmodule

// File: doc/cbi980_tx_serializer.md
Name: cbi980_tx_serializer

Overview:
Transmit-side serial engine for the cbi980 stereo audio link. It drains the channel-0 and channel-1 transmit word streams through per-channel valid/ready handshakes. It emits the two-slot serial frame (sclk, lrclk, sdout) using the line configuration the core exposes: mclk_rate, octet_cnt, rjust and lsb_first. It flags per-channel underruns back to the core's tx_unf status bits.

Parameters:
SLOT_BITS, 32, bit clocks per slot; frame = 2*SLOT_BITS bit clocks; must be >= 32.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
txen  input  1  transmit enable (core CR.txen)
mclk_rate  input  3  sclk half-period = mclk_rate+1 clk cycles
octet_cnt  input  3  data bytes per slot; 1..4 used as is, 0 and 5..7 treated as 4
rjust  input  1  1 = data right-justified in slot, 0 = left-justified
lsb_first  input  1  1 = LSB shifted first, 0 = MSB first
ch0_data  input  32  channel-0 word; low 8*octet_cnt bits used
ch0_valid  input  1  channel-0 word available
ch0_ready  output  1  one-cycle fetch strobe for channel 0
ch1_data  input  32  channel-1 word
ch1_valid  input  1  channel-1 word available
ch1_ready  output  1  one-cycle fetch strobe for channel 1
tx_unf  output  2  one-cycle underrun pulse; [1] = ch1, [0] = ch0
sclk  output  1  serial bit clock
lrclk  output  1  slot select; 0 = ch0 slot, 1 = ch1 slot
sdout  output  1  serial data
busy  output  1  high while in SLOT0/SLOT1

Behaviour:
- Reset: state IDLE; sclk, lrclk, sdout, busy, ch0_ready, ch1_ready and tx_unf all 0; all counters 0. rst mid-frame aborts immediately, with no partial-frame completion.
- States: IDLE, SLOT0, SLOT1.
- IDLE -> SLOT0 on the cycle after txen is sampled high.
- SLOT0 -> SLOT1 at the end of slot-0 bit SLOT_BITS-1.
- SLOT1 -> SLOT0 at the end of the frame if txen=1, else SLOT1 -> IDLE.
- Clearing txen mid-frame completes the current frame (both slots) before going idle.
- Slot entry cycle (first cycle in SLOT0 or SLOT1):
  - chN_ready is high for exactly that one cycle.
  - If chN_valid=1, the word is taken (valid & ready = transfer).
  - If chN_valid=0, the slot transmits all zeros and tx_unf[N] pulses high for that same cycle.
  - ready is never asserted outside slot-entry cycles.
- Config latching: mclk_rate, octet_cnt, rjust and lsb_first are latched on SLOT0 entry and held for the whole frame. Changes mid-frame take effect at the next frame.
- Bit timing:
  - sclk is 0 on slot entry, rises after mclk_rate+1 clk, and falls after a further mclk_rate+1 clk.
  - One bit = 2*(mclk_rate+1) clk; frame = 2*SLOT_BITS*2*(mclk_rate+1) clk.
  - sdout and lrclk change only when sclk falls (or on slot entry); the receiver samples on the rising edge.
  - There is no I2S one-bit delay: bit 0 of a slot is driven on the slot entry cycle, and lrclk changes together with bit 0.
- Slot data, with N = 8*octet_cnt(eff) and D = word[N-1:0]:
  - Left-justified (rjust=0): bit positions 0..N-1 carry D; the rest are 0.
  - Right-justified (rjust=1): positions SLOT_BITS-N..SLOT_BITS-1 carry D; the rest are 0.
  - MSB first: D[N-1] first. lsb_first=1: D[0] first.
- Continuous operation has no gap between frames: the SLOT1 last-bit sclk falling edge coincides with SLOT0 entry of the next frame.
- IDLE outputs: sclk=0, lrclk=0, sdout=0, busy=0.
- Simultaneous events:
  - rst has priority over everything.
  - txen falling on the same cycle as the frame end -> IDLE.
  - txen rising during IDLE is acted on only from IDLE.

Test Plan:
1. Reset, then txen=1, mclk_rate=0, octet_cnt=1, MSB first, left-justified, ch0=0x000000A5, ch1=0x0000005A, both valid -> ch0_ready at cycle 1 and ch1_ready at cycle 65. Slot0 sdout = 1,0,1,0,0,1,0,1 then 24 zeros; slot1 = 0,1,0,1,1,0,1,0 then zeros. Each bit lasts 2 clk; lrclk rises at cycle 65.
2. Same setup with rjust=1, ch0=0x00000001 -> slot0 = 31 zeros then 1. With lsb_first=1, rjust=0 -> slot0 = 1 then 31 zeros.
3. octet_cnt=0 and octet_cnt=7, ch0=0x80000001, MSB first, left-justified -> both give a full 32-bit slot: 1, 30 zeros, 1.
4. mclk_rate=3 -> sclk high 4 clk, low 4 clk; frame length 512 clk; octet_cnt changed mid-frame applies only from the next SLOT0 entry.
5. ch1_valid=0 at SLOT1 entry -> tx_unf=2'b10 for one cycle, slot1 all zeros, no ch1 transfer. ch0 continues normally in the next frame.
6. Drop txen during slot0 -> frame completes through bit 63, then IDLE with busy=0 and all outputs 0. Assert rst mid-slot -> next cycle outputs all 0 and state IDLE.
